iter_shift_unit: RTL and testbench

//  Multi-cycle, parametrised barrel-shift replacement for the ALU shift path.

---
 rtl/iter_shift_unit.sv | 140 ++++++++++++++
 tb/tb_iter_shift_unit.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/iter_shift_unit.sv
// iter_shift_unit
//   Multi-cycle replacement for the ALU barrel shifter. Performs SLL, SRL and
//   SRA (and ROTR when ITER_SHIFT_ROTATE_EN is defined) on a WIDTH-bit value.
//   Each clock shifts by at most STEP bits. Flags follow the other ALU units.
//
//   Build option: ITER_SHIFT_ROTATE_EN
//     defined     : op=11 rotates right
//     not defined : op=11 behaves exactly as SRL, and no rotate logic is built
//
//   Ports
//     clk, reset       rising-edge clock, synchronous active-high reset
//     in_valid/ready   issue handshake; in_ready is high only in IDLE
//     op               00 SLL, 01 SRL, 10 SRA, 11 ROTR/SRL
//     A                shift amount; only A[SHAMT_W-1:0] is used
//     B                value to shift
//     out_valid/ready  completion handshake
//     S, Z, V, N       result, zero, overflow (always 0), negative
//     dbg_state        current FSM state (0 IDLE, 1 SHIFT, 2 DONE)
//
//   Handshakes: a transfer happens on a rising edge where valid and ready are
//   both high. The producer holds valid (and data) until that edge. The
//   consumer may change ready freely. This unit never drops out_valid before
//   the transfer.
module iter_shift_unit #(
  parameter int WIDTH   = 32,
  parameter int STEP    = 4,
  parameter int SHAMT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             Z,
  output logic             V,
  output logic             N,
  output logic [1:0]       dbg_state
);

  // One extra bit so both STEP (up to WIDTH) and WIDTH fit.
  localparam int KW = SHAMT_W + 1;
  localparam logic [KW-1:0] STEP_K = KW'(STEP);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state, state_nx;
  logic [1:0]         op_q;
  logic [WIDTH-1:0]   work;
  logic [WIDTH-1:0]   shifted;
  logic [SHAMT_W-1:0] rem;
  logic [KW-1:0]      rem_ext;
  logic [KW-1:0]      k;
  logic               unused_a;

  // Upper bits of A never matter: the amount is taken modulo WIDTH.
  assign unused_a = ^A[WIDTH-1:SHAMT_W];

  // This cycle's shift distance: k = min(STEP, rem).
  always_comb begin
    rem_ext = {1'b0, rem};
    k       = (rem_ext > STEP_K) ? STEP_K : rem_ext;
  end

  // One iteration of the shift. For SRA the MSB of the work register is
  // always the sign bit of the latched B, so an arithmetic shift fills with it.
  always_comb begin
    shifted = work;
    case (op_q)
      2'b00:   shifted = work << k;
      2'b01:   shifted = work >> k;
      2'b10:   shifted = $unsigned($signed(work) >>> k);
`ifdef ITER_SHIFT_ROTATE_EN
      // Rotating is only done while rem != 0, so k is in 1..WIDTH-1 here.
      default: shifted = (work >> k) | (work << (KW'(WIDTH) - k));
`else
      default: shifted = work >> k;
`endif
    endcase
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid) state_nx = SHIFT;
      SHIFT:   if (rem == '0) state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      op_q  <= 2'b00;
      work  <= '0;
      rem   <= '0;
      S     <= '0;
      Z     <= 1'b0;
      N     <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_q <= op;
            work <= B;
            rem  <= A[SHAMT_W-1:0];
          end
        end
        SHIFT: begin
          if (rem != '0) begin
            work <= shifted;
            rem  <= rem - k[SHAMT_W-1:0];
          end else begin
            S <= work;
            Z <= (work == '0);
            N <= work[WIDTH-1];
          end
        end
        default: ;
      endcase
    end
  end

  // in_ready is gated by reset so a request is never accepted while reset is asserted.
  assign in_ready  = (state == IDLE) && !reset;
  assign out_valid = (state == DONE);
  assign V         = 1'b0;
  assign dbg_state = state;

endmodule

// File: tb/tb_iter_shift_unit.sv
module tb_iter_shift_unit;

  localparam int WIDTH   = 32;
  localparam int STEP    = 4;
  localparam int SHAMT_W = 5;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [1:0]       op = 2'b00;
  logic [WIDTH-1:0] A = '0;
  logic [WIDTH-1:0] B = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] S;
  logic             Z, V, N;
  logic [1:0]       dbg_state;

  int n_checks = 0;
  int n_pass   = 0;
  logic [WIDTH-1:0] exp_q[$];

  iter_shift_unit #(.WIDTH(WIDTH), .STEP(STEP), .SHAMT_W(SHAMT_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .A(A), .B(B), .out_valid(out_valid), .out_ready(out_ready),
    .S(S), .Z(Z), .V(V), .N(N), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // ---------------- reference model ----------------
  function automatic logic [WIDTH-1:0] model(input logic [1:0] o, input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
    int amt;
    amt = int'(a % WIDTH);
    case (o)
      2'd0: return b << amt;
      2'd1: return b >> amt;
      2'd2: return $unsigned($signed(b) >>> amt);
`ifdef ITER_SHIFT_ROTATE_EN
      default: return (amt == 0) ? b : ((b >> amt) | (b << (WIDTH - amt)));
`else
      default: return b >> amt;
`endif
    endcase
  endfunction

  // ---------------- driver ----------------
  // Issues one request, checks latency, holds out_ready low for 'hold' cycles
  // checking stability, then consumes the result. With 'poke' set, a second
  // request is presented during DONE; it must not be taken.
  task automatic issue(input logic [1:0] o, input logic [WIDTH-1:0] a,
                       input logic [WIDTH-1:0] b, input int hold, input bit poke);
    logic [WIDTH-1:0] exp;
    int amt, exp_lat, lat, n;
    exp_q.push_back(model(o, a, b));
    amt     = int'(a % WIDTH);
    exp_lat = (amt + STEP - 1) / STEP + 1;

    @(negedge clk);
    in_valid = 1'b1; op = o; A = a; B = b;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check("in_ready_timeout", {31'd0, in_ready}, 32'd1);
      in_valid = 1'b0;
      void'(exp_q.pop_front());
      return;
    end
    @(posedge clk);
    #1;
    // Scramble inputs after the accept edge; the unit must ignore them.
    in_valid = 1'b0; op = 2'($urandom_range(0, 3)); A = $urandom; B = $urandom;

    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
      if (!out_valid && lat < exp_lat) check("busy_in_ready", {31'd0, in_ready}, 32'd0);
    end while (!out_valid && lat < 40);
    check("latency", lat, exp_lat);
    exp = exp_q.pop_front();
    if (!out_valid) return;
    check("S", S, exp);
    check("Z", {31'd0, Z}, {31'd0, exp == '0});
    check("N", {31'd0, N}, {31'd0, exp[WIDTH-1]});
    check("V", {31'd0, V}, 32'd0);

    if (poke) begin
      in_valid = 1'b1; op = 2'd0; A = 32'd3; B = 32'hFFFF_FFFF;
    end
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check("hold_valid", {31'd0, out_valid}, 32'd1);
      check("hold_S", S, exp);
      check("hold_in_ready", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check("drop_valid", {31'd0, out_valid}, 32'd0);
    check("idle_in_ready", {31'd0, in_ready}, 32'd1);
    if (poke) begin
      // The poked request must not have started anything.
      @(posedge clk);
      #1;
      check("poke_ignored", {31'd0, out_valid}, 32'd0);
      check("poke_S", S, exp);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_S", S, 32'd0);
    check("rst_Z", {31'd0, Z}, 32'd0);
    check("rst_N", {31'd0, N}, 32'd0);
    check("rst_V", {31'd0, V}, 32'd0);
    reset = 1'b0;
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // SRA of most negative value by 31: 9-cycle latency
    issue(2'd2, 32'd31, 32'h8000_0000, 0, 1'b0);

    // Reset held 2 clocks mid-SHIFT aborts the operation
    @(negedge clk);
    in_valid = 1'b1; op = 2'd2; A = 32'd20; B = 32'h8123_4567;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
      check("abort_valid", {31'd0, out_valid}, 32'd0);
    end
    reset = 1'b0;
    #1;
    check("abort_in_ready", {31'd0, in_ready}, 32'd1);
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      check("abort_no_valid", {31'd0, out_valid}, 32'd0);
    end
    check("abort_S", S, 32'd0);
    check("abort_Z", {31'd0, Z}, 32'd0);
    check("abort_N", {31'd0, N}, 32'd0);

    // amt = 0 via A=32
    issue(2'd1, 32'd32, 32'h8000_0000, 0, 1'b0);
    // Result held while consumer stalls
    issue(2'd0, 32'd5, 32'h0000_0001, 3, 1'b0);
    // Zero result, request presented during DONE is not taken
    issue(2'd1, 32'd4, 32'h0000_000F, 2, 1'b1);
    // op=11
    issue(2'd3, 32'd1, 32'h0000_0001, 0, 1'b0);
    // Amount boundaries exercising partial last steps
    issue(2'd3, 32'd7, 32'h1234_5678, 1, 1'b0);
    issue(2'd0, 32'd4, 32'hDEAD_BEEF, 0, 1'b0);

    // Random traffic
    for (int t = 0; t < 40; t++)
      issue(2'($urandom_range(0, 3)), $urandom, $urandom, $urandom_range(0, 3), 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1);
  end

endmodule
